// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: instruction fields, memory handshake and datapath controls between the control FSM and the datapath.
interface mc_control_unit_if #(parameter int OPW = 7);
  logic [OPW-1:0] op_i;
  logic [2:0]     funct3_i;
  logic           funct7b5_i;
  logic           zero_i;
  logic           mem_ready_i;
  logic           mem_req_o;
  logic           mem_we_o;
  logic           adr_src_o;
  logic           ir_write_o;
  logic           pc_write_o;
  logic           reg_write_o;
  logic [1:0]     result_src_o;
  logic [1:0]     alu_src_a_o;
  logic [1:0]     alu_src_b_o;
  logic [2:0]     alu_control_o;
  logic [1:0]     imm_src_o;
  logic           illegal_o;
  logic [3:0]     state_o;
  modport master (
    input  op_i, funct3_i, funct7b5_i, zero_i, mem_ready_i,
    output mem_req_o, mem_we_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
           result_src_o, alu_src_a_o, alu_src_b_o, alu_control_o, imm_src_o,
           illegal_o, state_o
  );
  modport slave (
    output op_i, funct3_i, funct7b5_i, zero_i, mem_ready_i,
    input  mem_req_o, mem_we_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
           result_src_o, alu_src_a_o, alu_src_b_o, alu_control_o, imm_src_o,
           illegal_o, state_o
  );
endinterface

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle RV32 control FSM (lw, sw, R/I ALU, beq, jal) with a ready/request memory handshake.
module mc_control_unit #(parameter int OPW = 7) (
  input logic clk_i,
  input logic rst_i,
  mc_control_unit_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_ALUWB = 4'd7,
    S_EXECI = 4'd8, S_JAL = 4'd9, S_BEQ = 4'd10
  } state_t;
  localparam logic [OPW-1:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                             OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;
  state_t r_state;
  logic w_req, w_we, w_adr, w_irw, w_pcw, w_rw, w_ill;
  logic [1:0] w_rs, w_sa, w_sb;
  logic [2:0] w_alu, w_alu_dec;
  logic w_legal;
  logic [OPW-1:0] w_op;
  assign w_op = bus.op_i;
  assign w_legal = (w_op == OP_LW) || (w_op == OP_SW) || (w_op == OP_R) ||
                   (w_op == OP_I) || (w_op == OP_JAL) || (w_op == OP_BEQ);
  assign w_alu_dec = (bus.funct3_i == 3'b000) ? ((w_op[5] & bus.funct7b5_i) ? 3'b001 : 3'b000) :
                     (bus.funct3_i == 3'b010) ? 3'b101 :
                     (bus.funct3_i == 3'b110) ? 3'b011 :
                     (bus.funct3_i == 3'b111) ? 3'b010 : 3'b000;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_FETCH;
    else case (r_state)
      S_FETCH:    r_state <= bus.mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE:   r_state <= (w_op == OP_LW || w_op == OP_SW) ? S_MEMADR :
                             (w_op == OP_R)   ? S_EXECR :
                             (w_op == OP_I)   ? S_EXECI :
                             (w_op == OP_JAL) ? S_JAL :
                             (w_op == OP_BEQ) ? S_BEQ : S_FETCH;
      S_MEMADR:   r_state <= w_op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  r_state <= bus.mem_ready_i ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: r_state <= bus.mem_ready_i ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: r_state <= S_ALUWB;
      default:    r_state <= S_FETCH;
    endcase
  end
  always_comb begin
    w_req = 1'b0;
    w_we  = 1'b0;
    w_adr = 1'b0;
    w_irw = 1'b0;
    w_pcw = 1'b0;
    w_rw  = 1'b0;
    w_ill = 1'b0;
    w_rs  = 2'b00;
    w_sa  = 2'b00;
    w_sb  = 2'b00;
    w_alu = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        w_irw = bus.mem_ready_i;
        w_pcw = bus.mem_ready_i;
        w_sb  = 2'b10;
        w_rs  = 2'b10;
      end
      S_DECODE: begin
        w_sa  = 2'b01;
        w_sb  = 2'b01;
        w_ill = !w_legal;
      end
      S_MEMADR: begin
        w_sa = 2'b10;
        w_sb = 2'b01;
      end
      S_MEMREAD: begin
        w_req = 1'b1;
        w_adr = 1'b1;
      end
      S_MEMWB: begin
        w_rs = 2'b01;
        w_rw = 1'b1;
      end
      S_MEMWRITE: begin
        w_req = 1'b1;
        w_we  = 1'b1;
        w_adr = 1'b1;
      end
      S_EXECR: begin
        w_sa  = 2'b10;
        w_alu = w_alu_dec;
      end
      S_EXECI: begin
        w_sa  = 2'b10;
        w_sb  = 2'b01;
        w_alu = w_alu_dec;
      end
      S_ALUWB: w_rw = 1'b1;
      S_JAL: begin
        w_sa  = 2'b01;
        w_sb  = 2'b10;
        w_pcw = 1'b1;
      end
      S_BEQ: begin
        w_sa  = 2'b10;
        w_alu = 3'b001;
        w_pcw = bus.zero_i;
      end
      default: ;
    endcase
  end
  // strobes are gated by reset so nothing is written once rst_i falls mid-instruction
  assign bus.mem_req_o     = rst_i & w_req;
  assign bus.mem_we_o      = rst_i & w_we;
  assign bus.ir_write_o    = rst_i & w_irw;
  assign bus.pc_write_o    = rst_i & w_pcw;
  assign bus.reg_write_o   = rst_i & w_rw;
  assign bus.illegal_o     = rst_i & w_ill;
  assign bus.adr_src_o     = w_adr;
  assign bus.result_src_o  = w_rs;
  assign bus.alu_src_a_o   = w_sa;
  assign bus.alu_src_b_o   = w_sb;
  assign bus.alu_control_o = w_alu;
  assign bus.imm_src_o     = (w_op == OP_SW) ? 2'b01 : (w_op == OP_BEQ) ? 2'b10 :
                             (w_op == OP_JAL) ? 2'b11 : 2'b00;
  assign bus.state_o       = r_state;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: per-cycle vector table for each instruction class plus async reset sequences.
module tb_mc_control_unit;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  mc_control_unit_if bus ();
  mc_control_unit dut (.clk_i(clk), .rst_i(rst_i), .bus(bus.master));
  always #5 clk = ~clk;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011,
                         BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        rdy;
    logic [21:0] exp;
  } vec_t;
  vec_t vq[$];
  task automatic v(input logic [6:0] op, input logic [2:0] f3, input logic f7, z, rdy,
                   input logic [3:0] st, input logic [5:0] en, input logic [1:0] rs, sa, sb,
                   input logic [2:0] alu, input logic [1:0] imm, input logic ill);
    vq.push_back('{op, f3, f7, z, rdy, {st, en, rs, sa, sb, alu, imm, ill}});
  endtask
  function automatic logic [21:0] act();
    return {bus.state_o, bus.mem_req_o, bus.mem_we_o, bus.adr_src_o, bus.ir_write_o,
            bus.pc_write_o, bus.reg_write_o, bus.result_src_o, bus.alu_src_a_o,
            bus.alu_src_b_o, bus.alu_control_o, bus.imm_src_o, bus.illegal_o};
  endfunction
  task automatic chk(input string name, input logic [21:0] a, input logic [21:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %06h expected %06h", name, a, e);
    end
  endtask
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7, z, rdy);
    bus.op_i = op;
    bus.funct3_i = f3;
    bus.funct7b5_i = f7;
    bus.zero_i = z;
    bus.mem_ready_i = rdy;
  endtask
  task automatic alu4(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    v(op, f3, f7, 0, 1, 0, 6'b100110, 2, 0, 2, 0, 0, 0);
    v(op, f3, f7, 0, 1, 1, 6'b000000, 0, 1, 1, 0, 0, 0);
    v(op, f3, f7, 0, 1, (op == R) ? 4'd6 : 4'd8, 6'b000000, 0, 2, (op == R) ? 2'd0 : 2'd1, alu, 0, 0);
    v(op, f3, f7, 0, 1, 7, 6'b000001, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    alu4(R, 3'b000, 1, 3'b001);
    alu4(R, 3'b111, 0, 3'b010);
    alu4(R, 3'b110, 0, 3'b011);
    alu4(I, 3'b000, 1, 3'b000);
    alu4(I, 3'b010, 0, 3'b101);
    alu4(I, 3'b100, 0, 3'b000);
    v(LW, 2, 0, 0, 0, 0, 6'b100000, 2, 0, 2, 0, 0, 0);
    v(LW, 2, 0, 0, 0, 0, 6'b100000, 2, 0, 2, 0, 0, 0);
    v(LW, 2, 0, 0, 1, 0, 6'b100110, 2, 0, 2, 0, 0, 0);
    v(LW, 2, 0, 0, 1, 1, 6'b000000, 0, 1, 1, 0, 0, 0);
    v(LW, 2, 0, 0, 1, 2, 6'b000000, 0, 2, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) v(LW, 2, 0, 0, 0, 3, 6'b101000, 0, 0, 0, 0, 0, 0);
    v(LW, 2, 0, 0, 1, 3, 6'b101000, 0, 0, 0, 0, 0, 0);
    v(LW, 2, 0, 0, 1, 4, 6'b000001, 1, 0, 0, 0, 0, 0);
    v(SW, 2, 0, 0, 1, 0, 6'b100110, 2, 0, 2, 0, 1, 0);
    v(SW, 2, 0, 0, 1, 1, 6'b000000, 0, 1, 1, 0, 1, 0);
    v(SW, 2, 0, 0, 1, 2, 6'b000000, 0, 2, 1, 0, 1, 0);
    v(SW, 2, 0, 0, 0, 5, 6'b111000, 0, 0, 0, 0, 1, 0);
    v(SW, 2, 0, 0, 1, 5, 6'b111000, 0, 0, 0, 0, 1, 0);
    for (int z = 1; z >= 0; z--) begin
      v(BQ, 0, 0, z[0], 1, 0, 6'b100110, 2, 0, 2, 0, 2, 0);
      v(BQ, 0, 0, z[0], 1, 1, 6'b000000, 0, 1, 1, 0, 2, 0);
      v(BQ, 0, 0, z[0], 1, 10, z[0] ? 6'b000010 : 6'b000000, 0, 2, 0, 1, 2, 0);
    end
    v(JL, 0, 0, 0, 1, 0, 6'b100110, 2, 0, 2, 0, 3, 0);
    v(JL, 0, 0, 0, 1, 1, 6'b000000, 0, 1, 1, 0, 3, 0);
    v(JL, 0, 0, 0, 1, 9, 6'b000010, 0, 1, 2, 0, 3, 0);
    v(JL, 0, 0, 0, 1, 7, 6'b000001, 0, 0, 0, 0, 3, 0);
    for (int k = 0; k < 2; k++) begin
      v(BAD, 0, 0, 0, 1, 0, 6'b100110, 2, 0, 2, 0, 0, 0);
      v(BAD, 0, 0, 0, 1, 1, 6'b000000, 0, 1, 1, 0, 0, 1);
    end
    drive(SW, 2, 0, 0, 1);
    #2;
    chk("reset_state", act(), {4'd0, 6'b000000, 2'd2, 2'd0, 2'd2, 3'd0, 2'd1, 1'b0});
    @(negedge clk);
    rst_i = 1'b1;
    foreach (vq[i]) begin
      drive(vq[i].op, vq[i].f3, vq[i].f7, vq[i].z, vq[i].rdy);
      #1;
      chk($sformatf("vec%0d", i), act(), vq[i].exp);
      @(negedge clk);
    end
    chk("after_illegal", act(), {4'd0, 6'b100110, 2'd2, 2'd0, 2'd2, 3'd0, 2'd0, 1'b0});
    drive(SW, 2, 0, 0, 1);
    repeat (3) @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    chk("sw_wait", act(), {4'd5, 6'b111000, 2'd0, 2'd0, 2'd0, 3'd0, 2'd1, 1'b0});
    #1 rst_i = 1'b0;
    #1;
    chk("async_rst", act(), {4'd0, 6'b000000, 2'd2, 2'd0, 2'd2, 3'd0, 2'd1, 1'b0});
    @(negedge clk);
    rst_i = 1'b1;
    bus.mem_ready_i = 1'b1;
    #1;
    chk("post_rst_fetch", act(), {4'd0, 6'b100110, 2'd2, 2'd0, 2'd2, 3'd0, 2'd1, 1'b0});
    @(negedge clk);
    drive(LW, 2, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    chk("lw_read", act(), {4'd3, 6'b101000, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0});
    @(posedge clk);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_in_memread", act(), {4'd0, 6'b000000, 2'd2, 2'd0, 2'd2, 3'd0, 2'd0, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
